avsd_pll_ctrl: RTL and testbench



---
 rtl/avsd_pll_pkg.sv | 21 ++
 rtl/avsd_pll_ctrl_if.sv | 22 ++
 rtl/avsd_edge_meter.sv | 44 ++++
 rtl/avsd_pll_ctrl.sv | 130 +++++++++++++
 tb/tb_avsd_pll_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/avsd_pll_pkg.sv
// Shared types and helpers for the avsd_pll_1v8 enable/lock sequencer.
// Holds the sequencer state encoding, the default counter width and the window-quality test.
package avsd_pll_pkg;

    localparam int CNT_W_DEF = 12;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        LOCKED  = 3'd3,
        RESTART = 3'd4,
        FAULT   = 3'd5
    } pll_state_e;

    function automatic logic win_good(input int unsigned cnt, input int unsigned lo,
                                      input int unsigned hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/avsd_pll_ctrl_if.sv
// Request/status bundle between the SoC side and the PLL sequencer.
// slave is the sequencer's view; master is the requester's view.
interface avsd_pll_ctrl_if #(parameter int CNT_W = avsd_pll_pkg::CNT_W_DEF);
    logic             pll_en_req;
    logic             pll_div_in;
    logic             EN_VCO;
    logic             pll_locked;
    logic             clk_sel;
    logic             pll_fault;
    logic [1:0]       retry_cnt;
    logic [CNT_W-1:0] meas_cnt;

    modport master (
        output pll_en_req, pll_div_in,
        input  EN_VCO, pll_locked, clk_sel, pll_fault, retry_cnt, meas_cnt
    );

    modport slave (
        input  pll_en_req, pll_div_in,
        output EN_VCO, pll_locked, clk_sel, pll_fault, retry_cnt, meas_cnt
    );
endinterface

// File: rtl/avsd_edge_meter.sv
// Counts rising edges of the async divided PLL clock over fixed windows; edge lands in edge_cnt 3 cycles after the input rises.
// count is the saturated running total including this cycle's edge; win_done marks the last cycle of a window.
module avsd_edge_meter import avsd_pll_pkg::*; #(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int WIN_CYC = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic             run,
    output logic             win_done,
    output logic [CNT_W-1:0] count
);
    localparam int WIN_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

    logic [2:0]       sync_q;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             edge_pls;
    logic [CNT_W:0]   sum;

    // sync_q[1:0] is the synchronizer, sync_q[2] the delayed copy for edge detect
    assign edge_pls = sync_q[1] & ~sync_q[2];
    assign sum      = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, edge_pls};
    assign count    = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    assign win_done = run && (win_cnt == WIN_W'(WIN_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            sync_q <= {sync_q[1:0], div_in};
            if (!run || win_done) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end else begin
                win_cnt  <= win_cnt + 1'b1;
                edge_cnt <= count;
            end
        end
    end
endmodule

// File: rtl/avsd_pll_ctrl.sv
// Enable/lock sequencer for avsd_pll_1v8: power-up delay, windowed lock check, bounded restarts, fault.
// All outputs registered from the state register; dropping pll_en_req returns to OFF on the next edge.
module avsd_pll_ctrl import avsd_pll_pkg::*; #(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_CYC     = 256,
    parameter int EXP_MIN     = 120,
    parameter int EXP_MAX     = 136,
    parameter int GOOD_WIN    = 4,
    parameter int PWRUP_CYC   = 16,
    parameter int OFF_CYC     = 8,
    parameter int TIMEOUT_WIN = 32,
    parameter int MAX_RETRY   = 3
) (
    input logic            CLK,
    input logic            reset,
    avsd_pll_ctrl_if.slave bus
);
    localparam int TMR_MAX = (PWRUP_CYC > OFF_CYC) ? PWRUP_CYC : OFF_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int GOOD_W  = $clog2(GOOD_WIN + 1);
    localparam int TO_W    = $clog2(TIMEOUT_WIN + 1);

    pll_state_e       state;
    logic [TMR_W-1:0] timer;
    logic [GOOD_W-1:0] good_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [1:0]       retry_q;
    logic [CNT_W-1:0] meas_q;
    logic             en_vco_q, locked_q, fault_q;
    logic             run, win_done, good, drop;
    logic [CNT_W-1:0] count;

    avsd_edge_meter #(.CNT_W(CNT_W), .WIN_CYC(WIN_CYC)) u_meter (
        .clk      (CLK),
        .reset    (reset),
        .div_in   (bus.pll_div_in),
        .run      (run),
        .win_done (win_done),
        .count    (count)
    );

    assign run  = (state == MEASURE) || (state == LOCKED);
    assign good = win_good(32'(count), EXP_MIN, EXP_MAX);
    // a bad window ends the attempt when locked, or when it exhausts the measure timeout
    assign drop = win_done && !good &&
                  ((state == LOCKED) || (int'(to_cnt) + 1 >= TIMEOUT_WIN));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= OFF;
            timer    <= '0;
            good_cnt <= '0;
            to_cnt   <= '0;
            retry_q  <= '0;
            meas_q   <= '0;
            en_vco_q <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (!bus.pll_en_req) begin
            state    <= OFF;
            timer    <= '0;
            good_cnt <= '0;
            to_cnt   <= '0;
            retry_q  <= '0;
            en_vco_q <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            if (win_done) meas_q <= count;
            if (drop) begin
                en_vco_q <= 1'b0;
                locked_q <= 1'b0;
                if (retry_q == 2'(MAX_RETRY)) begin
                    state   <= FAULT;
                    fault_q <= 1'b1;
                end else begin
                    state   <= RESTART;
                    retry_q <= retry_q + 1'b1;
                    timer   <= TMR_W'(OFF_CYC - 1);
                end
            end else begin
                case (state)
                    OFF: begin
                        state <= SETTLE;
                        timer <= TMR_W'(PWRUP_CYC - 1);
                    end
                    SETTLE, RESTART: begin
                        if (timer == '0) begin
                            state    <= MEASURE;
                            en_vco_q <= 1'b1;
                            good_cnt <= '0;
                            to_cnt   <= '0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (win_done) begin
                            if (good) begin
                                if (int'(good_cnt) + 1 >= GOOD_WIN) begin
                                    state    <= LOCKED;
                                    locked_q <= 1'b1;
                                end else begin
                                    good_cnt <= good_cnt + 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                                to_cnt   <= to_cnt + 1'b1;
                            end
                        end
                    end
                    LOCKED, FAULT: ;
                    default: begin
                        state    <= OFF;
                        en_vco_q <= 1'b0;
                        locked_q <= 1'b0;
                        fault_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.EN_VCO     = en_vco_q;
    assign bus.pll_locked = locked_q;
    assign bus.clk_sel    = locked_q;
    assign bus.pll_fault  = fault_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.meas_cnt   = meas_q;
endmodule

// File: tb/tb_avsd_pll_ctrl.sv
// Directed bench for avsd_pll_ctrl: lock, timeout/fault, lock loss, abort, window bounds, saturation, reset.
module tb_avsd_pll_ctrl;
    import avsd_pll_pkg::*;

    logic CLK = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   div_half = 0;
    int   div_ph = 0;

    always #5 CLK = ~CLK;

    avsd_pll_ctrl_if #(.CNT_W(12)) dif ();
    avsd_pll_ctrl_if #(.CNT_W(12)) bif ();
    avsd_pll_ctrl_if #(.CNT_W(3))  sif ();

    assign sif.pll_en_req = dif.pll_en_req;
    assign sif.pll_div_in = dif.pll_div_in;

    avsd_pll_ctrl #(.CNT_W(12), .WIN_CYC(16), .EXP_MIN(6), .EXP_MAX(8), .GOOD_WIN(2),
                    .PWRUP_CYC(4), .OFF_CYC(3), .TIMEOUT_WIN(4), .MAX_RETRY(2))
        u_dut (.CLK(CLK), .reset(reset), .bus(dif.slave));

    // longer window so 9 edges fit; single-window lock and timeout expose each verdict
    avsd_pll_ctrl #(.CNT_W(12), .WIN_CYC(32), .EXP_MIN(6), .EXP_MAX(8), .GOOD_WIN(1),
                    .PWRUP_CYC(4), .OFF_CYC(3), .TIMEOUT_WIN(1), .MAX_RETRY(3))
        u_bnd (.CLK(CLK), .reset(reset), .bus(bif.slave));

    avsd_pll_ctrl #(.CNT_W(3), .WIN_CYC(16), .EXP_MIN(6), .EXP_MAX(8), .GOOD_WIN(2),
                    .PWRUP_CYC(4), .OFF_CYC(3), .TIMEOUT_WIN(4), .MAX_RETRY(2))
        u_sat (.CLK(CLK), .reset(reset), .bus(sif.slave));

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // one negedge step; the main divided clock advances only here
    task automatic tick();
        @(negedge CLK);
        if (div_half != 0) begin
            div_ph++;
            if (div_ph >= div_half) begin
                div_ph = 0;
                dif.pll_div_in = ~dif.pll_div_in;
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < 32; i++) begin
            bif.pll_div_in = (i < 2 * n) && (i % 2 == 0);
            tick();
        end
    endtask

    task automatic wait_b_en(input string tag);
        int k = 0;
        while (bif.EN_VCO !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check(tag, bif.EN_VCO, 1);
    endtask

    initial begin
        reset = 1'b1;
        dif.pll_en_req = 1'b0;
        dif.pll_div_in = 1'b0;
        bif.pll_en_req = 1'b0;
        bif.pll_div_in = 1'b0;
        div_half = 1;
        ticks(2);
        reset = 1'b0;
        check("rst_en_vco", dif.EN_VCO, 0);
        check("rst_locked", dif.pll_locked, 0);
        check("rst_clk_sel", dif.clk_sel, 0);
        check("rst_fault", dif.pll_fault, 0);
        check("rst_retry", dif.retry_cnt, 0);
        check("rst_meas", dif.meas_cnt, 0);

        // lock with period-2 input
        dif.pll_en_req = 1'b1;
        ticks(4);
        check("settle_en_lo", dif.EN_VCO, 0);
        tick();
        check("settle_en_hi", dif.EN_VCO, 1);
        ticks(16);
        check("win1_meas", dif.meas_cnt, 8);
        check("win1_locked", dif.pll_locked, 0);
        check("sat_meas", sif.meas_cnt, 7);
        ticks(16);
        check("lock_locked", dif.pll_locked, 1);
        check("lock_clk_sel", dif.clk_sel, 1);
        check("lock_meas", dif.meas_cnt, 8);

        // lock loss: last toggle lands in window 3, window 4 sees nothing
        ticks(13);
        div_half = 0;
        ticks(3);
        check("win3_meas", dif.meas_cnt, 8);
        check("win3_locked", dif.pll_locked, 1);
        ticks(16);
        check("loss_meas", dif.meas_cnt, 0);
        check("loss_locked", dif.pll_locked, 0);
        check("loss_clk_sel", dif.clk_sel, 0);
        check("loss_en_vco", dif.EN_VCO, 0);
        check("loss_retry", dif.retry_cnt, 1);
        div_half = 1;
        div_ph = 0;
        ticks(2);
        check("loss_off_en", dif.EN_VCO, 0);
        tick();
        check("loss_back_en", dif.EN_VCO, 1);
        ticks(32);
        check("relock_locked", dif.pll_locked, 1);
        check("relock_retry", dif.retry_cnt, 1);

        dif.pll_en_req = 1'b0;
        tick();
        check("drop_en_vco", dif.EN_VCO, 0);
        check("drop_locked", dif.pll_locked, 0);
        check("drop_retry", dif.retry_cnt, 0);
        check("drop_meas_hold", dif.meas_cnt, 8);

        // timeout with period-4 input, two restarts then fault
        div_half = 2;
        div_ph = 0;
        dif.pll_en_req = 1'b1;
        ticks(4);
        check("to_settle_lo", dif.EN_VCO, 0);
        tick();
        check("to_settle_hi", dif.EN_VCO, 1);
        for (int r = 1; r <= 2; r++) begin
            ticks(63);
            check($sformatf("to%0d_pre_en", r), dif.EN_VCO, 1);
            check($sformatf("to%0d_pre_retry", r), dif.retry_cnt, r - 1);
            tick();
            check($sformatf("to%0d_en", r), dif.EN_VCO, 0);
            check($sformatf("to%0d_retry", r), dif.retry_cnt, r);
            check($sformatf("to%0d_meas", r), dif.meas_cnt, 4);
            ticks(2);
            check($sformatf("to%0d_off_en", r), dif.EN_VCO, 0);
            tick();
            check($sformatf("to%0d_back_en", r), dif.EN_VCO, 1);
        end
        ticks(64);
        check("fault_flag", dif.pll_fault, 1);
        check("fault_en_vco", dif.EN_VCO, 0);
        check("fault_retry", dif.retry_cnt, 2);
        check("fault_state", u_dut.state, FAULT);

        dif.pll_en_req = 1'b0;
        tick();
        check("ab_fault_flag", dif.pll_fault, 0);
        check("ab_fault_retry", dif.retry_cnt, 0);
        check("ab_fault_meas", dif.meas_cnt, 4);

        // abort mid-measure
        div_half = 1;
        div_ph = 0;
        dif.pll_en_req = 1'b1;
        ticks(5);
        check("ab_meas_en_hi", dif.EN_VCO, 1);
        ticks(3);
        dif.pll_en_req = 1'b0;
        tick();
        check("ab_meas_en", dif.EN_VCO, 0);
        check("ab_meas_state", u_dut.state, OFF);

        // reset while locked
        dif.pll_en_req = 1'b1;
        ticks(37);
        check("rl_locked", dif.pll_locked, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rl_en_vco", dif.EN_VCO, 0);
        check("rl_locked_clr", dif.pll_locked, 0);
        check("rl_clk_sel", dif.clk_sel, 0);
        check("rl_meas", dif.meas_cnt, 0);
        check("rl_state", u_dut.state, OFF);

        // window bounds: 5 and 9 bad, 6 and 8 good
        bif.pll_en_req = 1'b1;
        wait_b_en("b_start");
        burst(5);
        check("b5_meas", bif.meas_cnt, 5);
        check("b5_retry", bif.retry_cnt, 1);
        check("b5_en_vco", bif.EN_VCO, 0);
        wait_b_en("b5_resume");
        burst(9);
        check("b9_meas", bif.meas_cnt, 9);
        check("b9_retry", bif.retry_cnt, 2);
        check("b9_locked", bif.pll_locked, 0);
        wait_b_en("b9_resume");
        burst(6);
        check("b6_meas", bif.meas_cnt, 6);
        check("b6_locked", bif.pll_locked, 1);
        burst(8);
        check("b8_meas", bif.meas_cnt, 8);
        check("b8_locked", bif.pll_locked, 1);
        burst(9);
        check("b9l_meas", bif.meas_cnt, 9);
        check("b9l_locked", bif.pll_locked, 0);
        check("b9l_retry", bif.retry_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end
endmodule
